// File: rtl/mux16_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants, FSM state encoding and a one-hot helper for
// the 16-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ  = 16;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 16;

  // Code 2'd3 is never entered; the FSM default branch sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } xfer_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: request, mux and downstream handshake signals of the
// arbiter.
//   master : arbiter side  (drives S, GNT, OUT_DATA, OUT_SRC, OUT_VALID)
//   slave  : environment   (drives REQ, MUX_OUT, OUT_READY)
//   REQ       requester i has a word on mux input Xi
//   S         mux select
//   MUX_OUT   mux output, combinational from S
//   GNT       one-hot pulse when a requester's word is captured
//   OUT_*     captured word, its source, valid/ready handshake
interface mux16_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]  REQ;
  logic [SEL_W-1:0]  S;
  logic [DATA_W-1:0] MUX_OUT;
  logic [N_REQ-1:0]  GNT;
  logic [DATA_W-1:0] OUT_DATA;
  logic [SEL_W-1:0]  OUT_SRC;
  logic              OUT_VALID;
  logic              OUT_READY;

  modport master (
    input  REQ, MUX_OUT, OUT_READY,
    output S, GNT, OUT_DATA, OUT_SRC, OUT_VALID
  );

  modport slave (
    output REQ, MUX_OUT, OUT_READY,
    input  S, GNT, OUT_DATA, OUT_SRC, OUT_VALID
  );

endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// mux_arb_pick: combinational round-robin winner selection.
//   req    request vector
//   ptr    highest-priority index for this round
//   winner first set req bit at or above ptr, wrapping 15->0
//   any    at least one request present
// The request vector is rotated so ptr lands on bit 0, priority-encoded from
// the bottom, and the result is rotated back by adding ptr (mod 16).
module mux_arb_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   idx;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
  end

  assign winner = idx + ptr;
  assign any    = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: shares an external 16:1 16-bit mux among 16 requesters.
// A registered select S is driven to the mux, the settled mux output is
// captured one cycle later and offered downstream with a valid/ready handshake.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux16_rr_arbiter_if.master (REQ, S, MUX_OUT, GNT, OUT_*)
// Build option MUXARB_FIXED_PRIO_EN: lowest requesting index always wins and
// the round-robin pointer is not kept. Handshake and timing are unchanged.
module mux16_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mux16_rr_arbiter_if.master    bus
);

  state_t           state;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] winner;
  logic             any;

`ifdef MUXARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [SEL_W-1:0] ptr;
  assign pick_ptr = ptr;
`endif

  mux_arb_pick u_pick (
    .req    (bus.REQ),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.S         <= '0;
      bus.GNT       <= '0;
      bus.OUT_DATA  <= '0;
      bus.OUT_SRC   <= '0;
      bus.OUT_VALID <= 1'b0;
`ifndef MUXARB_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.GNT <= '0;
          if (any) begin
            bus.S <= winner;
            state <= SEL;
          end
        end
        // S has been stable for a cycle, so MUX_OUT is the winner's word.
        // Captured even if the requester dropped REQ meanwhile.
        SEL: begin
          bus.OUT_DATA  <= bus.MUX_OUT;
          bus.OUT_SRC   <= bus.S;
          bus.GNT       <= onehot(bus.S);
          bus.OUT_VALID <= 1'b1;
          state         <= VALID;
        end
        VALID: begin
          bus.GNT <= '0;
          if (bus.OUT_READY) begin
            bus.OUT_VALID <= 1'b0;
`ifndef MUXARB_FIXED_PRIO_EN
            // Only the granted source moves the pointer past itself.
            ptr <= bus.S + SEL_W'(1);
`endif
            state <= IDLE;
          end
        end
        default: begin
          bus.GNT       <= '0;
          bus.OUT_VALID <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
